shifter_left_seq: RTL and testbench

SHIFTER_LEFT_SEQ -- requirements
Module: shifter_left_seq

---
 rtl/shifter_left_seq.sv | 77 +++++++
 tb/tb_shifter_left_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/shifter_left_seq.sv
// Sequential left shifter: IDLE -> SHIFT -> DONE, one bit per cycle (four with SHL_STEP4_EN).
// o_done lands in cycle count_cycles+1 after the start; starts are ignored while busy.
module shifter_left_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [SHW-1:0]   i_shamt,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SHW-1:0]   count_q, count_d;

`ifdef SHL_STEP4_EN
  logic [SHW-1:0] step;
  assign step = (count_q > SHW'(4)) ? SHW'(4) : count_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          data_d  = i_a;
          count_d = i_shamt;
          state_d = (i_shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
`ifdef SHL_STEP4_EN
        data_d  = data_q << step;
        count_d = count_q - step;
        if (count_q == step) state_d = ST_DONE;
`else
        data_d  = {data_q[WIDTH-2:0], 1'b0};
        count_d = count_q - SHW'(1);
        if (count_q == SHW'(1)) state_d = ST_DONE;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy   = (state_q != ST_IDLE);
  // Reset landing on the DONE cycle suppresses the pulse so an aborted op never reports.
  assign o_done   = (state_q == ST_DONE) && !i_rst;
  assign o_result = data_q;

endmodule

// File: tb/tb_shifter_left_seq.sv
// Randomized bench for shifter_left_seq against an arithmetic reference (a * 2**shamt).
module tb_shifter_left_seq;
  localparam int W  = 32;
  localparam int SW = $clog2(W);

  logic          i_clk = 1'b0;
  logic          i_rst, i_start;
  logic [W-1:0]  i_a;
  logic [SW-1:0] i_shamt;
  logic          o_busy, o_done;
  logic [W-1:0]  o_result;

  int checks = 0;
  int errors = 0;

  shifter_left_seq #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_a(i_a),
    .i_shamt(i_shamt), .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input int sh);
    longint unsigned prod;
    prod = longint'(a) * (64'd1 << sh);
    return prod[W-1:0];
  endfunction

  function automatic int ref_latency(input int sh);
`ifdef SHL_STEP4_EN
    return (sh + 3) / 4 + 1;
`else
    return sh + 1;
`endif
  endfunction

  // Launch one op, then scramble inputs (start held high when noisy) while it runs.
  task automatic run_op(input logic [W-1:0] a, input int sh, input bit noisy);
    logic [W-1:0] exp_res;
    int done_cyc;
    exp_res  = ref_result(a, sh);
    done_cyc = -1;
    chk("idle_busy", o_busy, 0);
    i_start = 1'b1; i_a = a; i_shamt = sh[SW-1:0];
    tick();
    for (int k = 1; k <= W + 4 && done_cyc < 0; k++) begin
      i_start = noisy; i_a = $urandom; i_shamt = SW'($urandom);
      chk("busy", o_busy, 1);
      if (o_done) done_cyc = k;
      else tick();
    end
    i_start = 1'b0;
    chk("done_cycle", 64'(done_cyc), 64'(ref_latency(sh)));
    chk("result", o_result, exp_res);
    tick();
    chk("post_done", o_done, 0);
    chk("post_busy", o_busy, 0);
    chk("hold", o_result, exp_res);
  endtask

  initial begin
    bit saw_done;
    i_rst = 1'b1; i_start = 1'b0; i_a = '0; i_shamt = '0;
    tick(); tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_result", o_result, 0);

    // Reset wins over a simultaneous start.
    i_start = 1'b1; i_a = 32'h1; i_shamt = 5'd1;
    tick();
    chk("rst_start_busy", o_busy, 0);
    chk("rst_start_result", o_result, 0);
    i_rst = 1'b0; i_start = 1'b0;
    tick();
    chk("idle_hold", o_busy, 0);

    run_op(32'h0000_0001, 31, 1'b0);
    run_op(32'hDEAD_BEEF, 0, 1'b0);
    run_op(32'h1234_5678, 3, 1'b0);   // back-to-back after zero-shift op
    run_op(32'hFFFF_FFFF, 16, 1'b1);
    run_op(32'h0000_0003, 7, 1'b0);

    // Abort in SHIFT: no pulse afterwards, state cleared.
    i_start = 1'b1; i_a = 32'h1; i_shamt = 5'd20;
    tick();
    i_start = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("abort_busy", o_busy, 0);
    chk("abort_result", o_result, 0);
    saw_done = 1'b0;
    for (int k = 6; k <= 30; k++) begin
      if (o_done) saw_done = 1'b1;
      tick();
    end
    chk("abort_no_done", saw_done, 0);

    // Reset landing on the DONE cycle.
    i_start = 1'b1; i_a = 32'h5; i_shamt = 5'd2;
    tick();
    i_start = 1'b0;
    while (!o_done && o_busy) tick();
    i_rst = 1'b1;
    #1;
    chk("rst_in_done_pulse", o_done, 0);
    tick();
    i_rst = 1'b0;
    chk("rst_in_done_busy", o_busy, 0);
    chk("rst_in_done_result", o_result, 0);
    tick();
    chk("rst_in_done_after", o_done, 0);

    for (int n = 0; n < 40; n++)
      run_op($urandom, int'($urandom_range(W - 1, 0)), 1'($urandom));
    run_op($urandom, W - 1, 1'b1);
    run_op($urandom, 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
